uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Serial line stage directly downstream of the simulator AXI-Lite UART model.
- Accepts transmit bytes over a valid/ready stream, buffers them in a FIFO, and drives an 8N1 asynchronous serial line on tx_o.
- The bench line monitor (or an FPGA pin) consumes tx_o.
- Provides a cycle-accurate UART TX path so console output timing matches the FPGA build.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 16, clk_i cycles per serial bit; at least 2.

Ports:
- clk_i  input  1  core clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- byte_i  input  8  byte to transmit.
- byte_valid_i  input  1  byte_i valid.
- byte_ready_o  output  1  FIFO can accept; equals !full.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  high when state != IDLE or FIFO not empty.
- fifo_level_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by the bench):
  - tx_o=1, state=IDLE, FIFO empty, fifo_level_o=0, byte_ready_o=1, busy_o=0.
  - Bit and baud counters are cleared.
  - Reset mid-frame aborts the frame immediately; tx_o returns high in the same instant.
- Push: byte_valid_i & byte_ready_o at a rising edge writes byte_i at the write pointer.
  - byte_i is ignored when !byte_valid_i.
  - Valid while full is not accepted and not lost; the producer holds it.
- Pop: the FSM pops the FIFO head into shift_q.
  - Simultaneous push and pop in one cycle: level unchanged, both pointers advance.
  - Push while full is impossible because byte_ready_o=0; there is no pass-through.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty, pop and go to START with baud_cnt=0.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx_o=shift_q[bit_idx], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. On the last STOP cycle, if FIFO non-empty, pop and go to START (no idle gap between frames); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width $clog2(CLKS_PER_BIT).
- Latency:
  - Byte pushed at edge N into an empty FIFO while IDLE: popped at edge N+1, tx_o=0 from edge N+2.
  - Frame length is 10*CLKS_PER_BIT cycles.
- busy_o is combinational from state and level. It falls in the cycle after the last STOP cycle when the FIFO is empty.
- All outputs are registered except byte_ready_o, busy_o and fifo_level_o, which decode registered state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx_o = ^shift_q (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; 8N1 framing exactly as above.

Decomposition:
- Shared package uart_pkg:
  - tx_state_e enum (IDLE, START, DATA, STOP, PARITY).
  - UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- One sub-module: uart_tx_fifo, a synchronous FIFO with async active-high reset.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, full, empty, level.
- The FSM, baud counter and shifter stay in the top.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0x55 at cycle 10 → tx_o=0 on cycles 12-15, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; busy_o low at cycle 52.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles → second start bit begins exactly 40 cycles after the first start bit, with no high gap beyond the stop bit; decoded bytes are 0xA5, 0x3C.
- Full FIFO: with tx busy, push 17 bytes 0x00..0x10 with valid held → byte_ready_o=0 at level 16; the 17th byte is accepted after the first pop; all 17 bytes decode in order.
- Simultaneous push/pop: level=1, push coincident with the STOP-end pop → fifo_level_o stays 1, pointers wrap correctly after 40 pushes.
- Reset mid-frame: assert rst_i during DATA bit 3 of 0xFF → tx_o=1, fifo_level_o=0, busy_o=0 immediately; the next push of 0x81 transmits cleanly.
- Parity (UART_TX_PARITY_EN defined): push 0x07 → parity bit 1; push 0x03 → parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART TX types and constants (state encoding, frame
//               width, idle line level).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous TX byte FIFO with async active-high reset and
//               combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_level == c_LVL_W'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : FIFO-buffered 8N1 UART transmitter. Define UART_TX_PARITY_EN
//               to insert an even-parity bit between data and stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [7:0]                      byte_i,
    input  logic                            byte_valid_i,
    output logic                            byte_ready_o,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(UART_DATA_BITS - 1);

    tx_state_e                 r_state;
    logic [c_BAUD_W-1:0]       r_baud;
    logic [c_BIT_W-1:0]        r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_bit_end;
    logic                      w_fifo_pop;
    logic [UART_DATA_BITS-1:0] w_rdata;

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    // Popping at the end of STOP lets frames run back to back with no gap
    assign w_fifo_pop = !w_empty && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (byte_valid_i),
        .pop   (w_fifo_pop),
        .wdata (byte_i),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= UART_IDLE_LEVEL;
        end else begin
            // Line level follows the state one cycle later
            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[r_bit];
`ifdef UART_TX_PARITY_EN
                PARITY:  r_tx <= ^r_shift;
`endif
                default: r_tx <= UART_IDLE_LEVEL;
            endcase

            if (r_state == IDLE || w_bit_end) r_baud <= '0;
            else                              r_baud <= r_baud + c_BAUD_W'(1);

            case (r_state)
                IDLE: begin
                    if (w_fifo_pop) begin
                        r_shift <= w_rdata;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == c_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) r_state <= STOP;
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (w_fifo_pop) begin
                            r_shift <= w_rdata;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_o         = r_tx;
    assign byte_ready_o = !w_full;
    assign busy_o       = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Scoreboard bench for uart_tx_serializer; a line monitor
//               captures each frame and compares it with queued bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;
    localparam int LIMIT     = 20000;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [4:0] fifo_level_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_push_edge = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    logic [FRAME_LEN-1:0] samp;
    int                   mcnt = 0;
    bit                   mact = 1'b0;

    uart_tx_serializer #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1
    task automatic check_frame(input logic [FRAME_LEN-1:0] got);
        logic [7:0]           b;
        logic [7:0]           dec;
        logic [FRAME_LEN-1:0] expw;
        logic                 lvl;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=0x%0h required=no_frame", got);
            return;
        end
        b = exp_q.pop_front();
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == 0)                           lvl = 1'b0;
            else if (i <= 8)                      lvl = b[i-1];
            else if (i == 9 && FRAME_BITS == 11)  lvl = (($countones(b) % 2) == 1);
            else                                  lvl = 1'b1;
            for (int j = 0; j < CPB; j++) expw[i*CPB+j] = lvl;
        end
        for (int k = 0; k < 8; k++) dec[k] = got[(k+1)*CPB + CPB/2];
        check("frame_byte", 64'(dec), 64'(b));
        check("frame_wave", 64'(got), 64'(expw));
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (tx_o === 1'b0) begin
                mact = 1'b1;
                samp = '0;
                mcnt = 1;
                start_q.push_back(cyc);
            end
        end else begin
            samp[mcnt] = tx_o;
            mcnt++;
            if (mcnt == FRAME_LEN) begin
                mact = 1'b0;
                check_frame(samp);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int k;
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (k = 0; k < LIMIT && !byte_ready_o; k++) begin
            @(posedge clk);
            #1;
        end
        if (!byte_ready_o) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=ready_low required=accept byte=0x%0h", b);
        end else begin
            exp_q.push_back(b);
            last_push_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_starts(input int n);
        int k;
        for (k = 0; k < LIMIT && start_q.size() < n; k++) @(negedge clk);
        check("start_timeout", 64'(start_q.size() >= n), 64'(1));
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < LIMIT && (busy_o || mact || exp_q.size() != 0); k++) @(negedge clk);
        check("drain_timeout", 64'(k >= LIMIT), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int bad;
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(tx_o), 64'(1));
        check("reset_ready", 64'(byte_ready_o), 64'(1));
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_level", 64'(fifo_level_o), 64'(0));
        rst_i = 1'b0;
        @(negedge clk);

        // Single byte: latency and busy fall
        start_q.delete();
        push_byte(8'h55);
        wait_starts(1);
        s = start_q[0];
        check("start_latency", 64'(s), 64'(last_push_edge + 2));
        wait_cyc(s + FRAME_LEN - 2);
        check("busy_in_frame", 64'(busy_o), 64'(1));
        wait_cyc(s + FRAME_LEN);
        check("busy_after_frame", 64'(busy_o), 64'(0));
        check("level_after_frame", 64'(fifo_level_o), 64'(0));
        drain();

        // Back-to-back frames
        start_q.delete();
        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_starts(2);
        check("b2b_spacing", 64'(start_q[1] - start_q[0]), 64'(FRAME_LEN));
        drain();

        // Fill the FIFO while the transmitter is busy
        start_q.delete();
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        check("full_level", 64'(fifo_level_o), 64'(16));
        check("full_ready", 64'(byte_ready_o), 64'(0));
        push_byte(8'h11);
        s = start_q[0];
        check("full_accept_edge", 64'(last_push_edge), 64'(s + FRAME_LEN));
        drain();
        check("full_frames", 64'(start_q.size()), 64'(18));
        bad = 0;
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME_LEN) bad++;
        check("full_gapless", 64'(bad), 64'(0));

        // Push coincident with the STOP-end pop
        start_q.delete();
        push_byte(8'h11);
        wait_starts(1);
        s = start_q[0];
        push_byte(8'h22);
        check("sim_level_before", 64'(fifo_level_o), 64'(1));
        wait_cyc(s + FRAME_LEN - 2);
        push_byte(8'h33);
        check("sim_push_edge", 64'(last_push_edge), 64'(s + FRAME_LEN - 1));
        check("sim_level_after", 64'(fifo_level_o), 64'(1));
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_byte(8'($urandom));
        end
        push_byte(8'h07);
        push_byte(8'h03);
        drain();

        // Reset during DATA bit 3
        start_q.delete();
        push_byte(8'hFF);
        push_byte(8'h12);
        push_byte(8'h34);
        wait_starts(1);
        s = start_q[0];
        wait_cyc(s + CPB + 3 * CPB + 1);
        check("rst_level_before", 64'(fifo_level_o), 64'(2));
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_tx", 64'(tx_o), 64'(1));
        check("rst_level", 64'(fifo_level_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_ready", 64'(byte_ready_o), 64'(1));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        start_q.delete();
        push_byte(8'h81);
        drain();
        check("post_rst_frames", 64'(start_q.size()), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
